// File: rtl/frame_stream_gate.sv
// frame_stream_gate: admits exactly one frame of W-bit beats per start
// command through a 2-entry skid buffer, then drains and pulses frame_done.
// A stop command aborts the frame and flushes the buffer.
// Ports: fclk, rst_n (async, active low), start, stop, frame_bytes[31:0],
//   din/din_valid/din_ready (upstream), dout/dout_valid/dout_ready
//   (downstream), busy, frame_done, frame_aborted, beats_out[CNT_W-1:0].
// Option: define FRAME_GATE_STALL_CNT_EN to add stall_cycles[31:0], a
//   saturating count of busy cycles with dout_valid & ~dout_ready.
module frame_stream_gate #(
   parameter int W     = 64,
   parameter int CNT_W = 29
) (
   input  logic             fclk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic [31:0]      frame_bytes,
   input  logic [W-1:0]     din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic [W-1:0]     dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             frame_done,
   output logic             frame_aborted,
   output logic [CNT_W-1:0] beats_out
`ifdef FRAME_GATE_STALL_CNT_EN
   ,
   output logic [31:0]      stall_cycles
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           st;
   state_t           st_nxt;
   logic [CNT_W-1:0] rem;
   logic [CNT_W-1:0] rem_nxt;
   logic [CNT_W-1:0] fb_beats;
   logic [1:0]       cnt;
   logic [1:0]       cnt_nxt;
   logic [W-1:0]     b0;
   logic [W-1:0]     b1;
   logic             push;
   logic             pop;
   logic             wr_hi;
   logic             clr;
   logic             done_nxt;
   logic             abort_nxt;
   logic             rdy_nxt;
   logic             unused_lsb;

   assign unused_lsb = ^frame_bytes[2:0];
   assign fb_beats   = CNT_W'(frame_bytes[31:3]);

   assign push       = din_valid & din_ready;
   assign pop        = dout_valid & dout_ready;
   assign dout_valid = (cnt != 2'd0);
   assign dout       = b0;
   assign busy       = (st != IDLE);

   // Slot the incoming beat lands in once this cycle's pop has shifted.
   assign wr_hi = (cnt == 2'd2) | ((cnt == 2'd1) & ~pop);

   always_comb begin
      st_nxt    = st;
      rem_nxt   = rem;
      cnt_nxt   = cnt + {1'b0, push} - {1'b0, pop};
      clr       = 1'b0;
      done_nxt  = 1'b0;
      abort_nxt = 1'b0;
      unique case (st)
         IDLE: begin
            if (start & ~stop) begin
               clr     = 1'b1;
               rem_nxt = fb_beats;
               if (fb_beats != '0) begin
                  st_nxt = RUN;
               end else begin
                  done_nxt = 1'b1;
               end
            end
         end
         RUN: begin
            if (push) begin
               rem_nxt = rem - CNT_W'(1);
               if (rem == CNT_W'(1)) begin
                  st_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Finish on the edge of the final pop so done follows it directly.
            if (cnt_nxt == 2'd0) begin
               st_nxt   = IDLE;
               done_nxt = 1'b1;
            end
         end
         default: st_nxt = IDLE;
      endcase
      if (stop && (st != IDLE)) begin
         st_nxt    = IDLE;
         cnt_nxt   = 2'd0;
         done_nxt  = 1'b0;
         abort_nxt = 1'b1;
      end
      rdy_nxt = (st_nxt == RUN) && (cnt_nxt != 2'd2) && (rem_nxt != '0);
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         st            <= IDLE;
         rem           <= '0;
         cnt           <= 2'd0;
         b0            <= '0;
         b1            <= '0;
         din_ready     <= 1'b0;
         frame_done    <= 1'b0;
         frame_aborted <= 1'b0;
         beats_out     <= '0;
      end else begin
         st            <= st_nxt;
         rem           <= rem_nxt;
         cnt           <= cnt_nxt;
         din_ready     <= rdy_nxt;
         frame_done    <= done_nxt;
         frame_aborted <= abort_nxt;
         if (!abort_nxt) begin
            if (pop) begin
               b0 <= b1;
            end
            if (push && !wr_hi) begin
               b0 <= din;
            end
            if (push && wr_hi) begin
               b1 <= din;
            end
         end
         if (clr) begin
            beats_out <= '0;
         end else if (pop) begin
            beats_out <= beats_out + CNT_W'(1);
         end
      end
   end

`ifdef FRAME_GATE_STALL_CNT_EN
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (clr) begin
         stall_cycles <= '0;
      end else if (busy && dout_valid && !dout_ready &&
                   (stall_cycles != 32'hFFFF_FFFF)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: doc/frame_stream_gate.md
# frame_stream_gate

Frame-bounded stream gate between the DRAM reader's 64-bit output stream and the application's input stream. On a start command it admits exactly one frame, `frame_bytes/8` beats, through a 2-entry registered skid buffer. It then blocks further input, drains, and pulses `frame_done`. A stop command aborts the frame and flushes buffered data, so the application never sees beats from a partial or overrun frame.

## Interface
- `W`, 64, data width in bits.
- `CNT_W`, 29, beat counter width (32-bit byte count >> 3).
- `fclk` input 1: clock.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: start-frame request, sampled only in IDLE.
- `stop` input 1: abort request, sampled in every state.
- `frame_bytes` input 32: frame size in bytes, latched on accepted start; bits [2:0] ignored.
- `din` input W: upstream data.
- `din_valid` input 1: upstream valid.
- `din_ready` output 1: upstream ready, registered.
- `dout` output W: downstream data.
- `dout_valid` output 1: downstream valid.
- `dout_ready` input 1: downstream ready.
- `busy` output 1: high in RUN or DRAIN.
- `frame_done` output 1: one-cycle pulse on normal frame completion.
- `frame_aborted` output 1: one-cycle pulse when stop ends a frame.
- `beats_out` output CNT_W: beats delivered downstream in the current or last frame.

## Operation
- States are IDLE, RUN and DRAIN. Reset enters IDLE.
- **IDLE:**
  - `start & ~stop` latches `remaining = frame_bytes[31:3]` and clears `beats_out`.
  - If `remaining` is nonzero, the next state is RUN.
  - If it is zero, the next state is IDLE and `frame_done` pulses the following cycle. No beats transfer.
  - `start & stop` together: stop wins and nothing happens.
- **RUN:**
  - A beat is accepted on `din_valid & din_ready`. Each accepted beat is written to the buffer and decrements `remaining`.
  - When `remaining` reaches 0 on an accept, the next state is DRAIN.
- **DRAIN:**
  - `din_ready` is 0.
  - When the buffer is empty, pulse `frame_done` and go to IDLE.
- **Buffer:**
  - 2-entry FIFO (skid), with `dout` driven from the head register.
  - Simultaneous push and pop when full is not allowed, because `din_ready` is low when full.
  - Simultaneous push and pop at 1 entry keeps the count at 1.
  - The count never exceeds 2.
- **beats_out:** increments on every `dout_valid & dout_ready` and wraps modulo 2^CNT_W.
- **stop in RUN or DRAIN:**
  - Next cycle: buffer emptied, `dout_valid` 0, `din_ready` 0, state IDLE, `frame_aborted` pulses.
  - Beats still held upstream are not consumed.
- **stop in IDLE:** no effect and no pulse.
- **Reset mid-frame:** all state is cleared asynchronously and no pulse is generated.

## Timing
- All outputs reset to 0: `din_ready`, `dout_valid`, `dout`, `busy`, `frame_done`, `frame_aborted`, `beats_out`.
- `din_ready` is registered: `din_ready` = (next state RUN) & (next buffer count < 2) & (next `remaining` > 0), i.e. (next buffer count < 2) & (next `remaining` > 0) & (next state == RUN). It never goes high for a beat beyond the frame.
- Latency: a beat accepted at edge N is valid on `dout` after edge N (visible in cycle N+1).
- Throughput: 1 beat/cycle sustained while `dout_ready` is held high.
- `busy` rises the cycle after the accepted start and falls in the same cycle as the `frame_done`/`frame_aborted` pulse.
- `frame_done` is asserted the cycle after the last beat's `dout` handshake.

## Configuration
- Macro `FRAME_GATE_STALL_CNT_EN`.
- **Defined:** adds output `stall_cycles` (32 bits, reset 0).
  - Cleared on accepted start.
  - Increments each cycle in RUN/DRAIN where `dout_valid & ~dout_ready` holds.
  - Saturates at 0xFFFFFFFF.
- **Undefined:** the port and the counter are absent. All other behaviour is identical.

## Test plan
- **Normal frame:** `frame_bytes`=64, `din_valid` and `dout_ready` held 1 → 8 beats delivered in order on consecutive cycles, `beats_out`=8, `frame_done` pulses exactly once, a 9th upstream beat is never accepted.
- **Backpressure:** `frame_bytes`=32, `dout_ready` toggles 1,0,0,1 … → no data loss or duplication, `din_ready` drops when 2 entries are held, 4 beats are delivered, and with the macro enabled `stall_cycles` equals the count of valid&~ready cycles.
- **Zero/odd size:** `frame_bytes`=0 → `frame_done` the cycle after start with no handshakes. `frame_bytes`=13 → exactly 1 beat transferred.
- **Abort:** `frame_bytes`=800, stop asserted after 10 beats accepted with 2 buffered → `dout_valid` 0 next cycle, `frame_aborted` pulses, no `frame_done`, state IDLE, a new start then runs a full frame.
- **Start/stop collision and reset:** `start`&`stop` in IDLE → remains IDLE. `rst_n` low mid-frame → all outputs 0 immediately, with no pulses.
